// File: rtl/vitals_uart_pkg.sv
// Shared definitions for the vitals UART receive path: parity and baud
// encodings, oversampling ratio, frame terminator and assembler states.
package vitals_uart_pkg;

  localparam logic [1:0] PARITY_NONE     = 2'b00;
  localparam logic [1:0] PARITY_ODD      = 2'b01;
  localparam logic [1:0] PARITY_EVEN     = 2'b10;
  localparam logic [1:0] PARITY_NONE_ALT = 2'b11;

  localparam logic [1:0] BAUD_2400  = 2'b00;
  localparam logic [1:0] BAUD_4800  = 2'b01;
  localparam logic [1:0] BAUD_9600  = 2'b10;
  localparam logic [1:0] BAUD_19200 = 2'b11;

  localparam int BAUD_2400_HZ  = 2400;
  localparam int BAUD_4800_HZ  = 4800;
  localparam int BAUD_9600_HZ  = 9600;
  localparam int BAUD_19200_HZ = 19200;

  localparam int         OVERSAMPLE   = 16;
  localparam logic [7:0] NEWLINE_BYTE = 8'h0A;

  typedef enum logic [2:0] {
    ASM_HUNT,
    ASM_WAIT_LO,
    ASM_WAIT_HI,
    ASM_WAIT_SPO2,
    ASM_WAIT_NL
  } asm_state_t;

  function automatic int baud_hz(input logic [1:0] code);
    case (code)
      BAUD_2400:  return BAUD_2400_HZ;
      BAUD_4800:  return BAUD_4800_HZ;
      BAUD_9600:  return BAUD_9600_HZ;
      default:    return BAUD_19200_HZ;
    endcase
  endfunction

  // Clocks per oversampling tick, truncated; never below 1 so the divider
  // still advances on a clock too slow for the selected rate.
  function automatic int tick_div_for(input int clk_hz, input logic [1:0] code);
    int d;
    d = clk_hz / (baud_hz(code) * OVERSAMPLE);
    if (d < 1) d = 1;
    return d;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Byte receiver: 2-flop synchroniser, 16x oversampling divider and the
// start/data/parity/stop bit state machine. Emits one byte per stop bit.
module uart_rx_byte
  import vitals_uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       data_rx,
  input  logic [1:0] parity_type,
  input  logic [1:0] baud_rate,
  output logic [7:0] rx_data,
  output logic       byte_done,
  output logic       byte_err,
  output logic       rx_active
);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  rx_state_t   state_reg;
  logic        rx_meta_reg, rx_sync_reg, rx_prev_reg;
  logic [1:0]  warm_cnt_reg;
  logic [15:0] div_cnt_reg;
  logic [3:0]  os_cnt_reg;
  logic [2:0]  bit_idx_reg;
  logic [7:0]  shift_reg;
  logic        parity_acc_reg, parity_bad_reg;
  logic [7:0]  rx_data_reg;
  logic        byte_done_reg, byte_err_reg, rx_active_reg;

  logic [15:0] div_table [4];
  logic [15:0] tick_div;
  logic        os_tick, fall_edge, parity_on, sample;

  for (genvar gi = 0; gi < 4; gi++) begin : g_div
    assign div_table[gi] = 16'(tick_div_for(CLK_FREQ_HZ, 2'(gi)));
  end

  assign tick_div  = div_table[baud_rate];
  assign os_tick   = (div_cnt_reg == tick_div - 16'd1);
  assign parity_on = (parity_type == PARITY_ODD) || (parity_type == PARITY_EVEN);
  assign sample    = rx_sync_reg;
  // Edges are only trusted once the sync chain holds real line samples,
  // so a line that is low at reset release is not mistaken for a start bit.
  assign fall_edge = (warm_cnt_reg == 2'd3) && rx_prev_reg && !rx_sync_reg;

  // Synchronise the RX line and track its previous value for edge detection
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_reg  <= 1'b1;
      rx_sync_reg  <= 1'b1;
      rx_prev_reg  <= 1'b1;
      warm_cnt_reg <= 2'd0;
    end else begin
      rx_meta_reg <= data_rx;
      rx_sync_reg <= rx_meta_reg;
      rx_prev_reg <= rx_sync_reg;
      if (warm_cnt_reg != 2'd3) warm_cnt_reg <= warm_cnt_reg + 2'd1;
    end
  end

  // Bit state machine: mid-bit sampling at oversampling tick 8 of each bit
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= RX_IDLE;
      div_cnt_reg    <= 16'd0;
      os_cnt_reg     <= 4'd0;
      bit_idx_reg    <= 3'd0;
      shift_reg      <= 8'd0;
      parity_acc_reg <= 1'b0;
      parity_bad_reg <= 1'b0;
      rx_data_reg    <= 8'd0;
      byte_done_reg  <= 1'b0;
      byte_err_reg   <= 1'b0;
      rx_active_reg  <= 1'b0;
    end else begin
      byte_done_reg <= 1'b0;
      byte_err_reg  <= 1'b0;
      if (state_reg != RX_IDLE) div_cnt_reg <= os_tick ? 16'd0 : div_cnt_reg + 16'd1;
      case (state_reg)
        RX_IDLE: begin
          if (fall_edge) begin
            state_reg     <= RX_START;
            div_cnt_reg   <= 16'd0;
            os_cnt_reg    <= 4'd0;
            rx_active_reg <= 1'b1;
          end
        end
        RX_START: begin
          if (os_tick) begin
            if (os_cnt_reg == 4'd7) begin
              os_cnt_reg <= 4'd0;
              if (sample) begin
                // Line back high at mid start bit: a glitch, not a byte
                state_reg     <= RX_IDLE;
                rx_active_reg <= 1'b0;
              end else begin
                state_reg      <= RX_DATA;
                bit_idx_reg    <= 3'd0;
                parity_acc_reg <= 1'b0;
                parity_bad_reg <= 1'b0;
              end
            end else begin
              os_cnt_reg <= os_cnt_reg + 4'd1;
            end
          end
        end
        RX_DATA: begin
          if (os_tick) begin
            os_cnt_reg <= os_cnt_reg + 4'd1;
            if (os_cnt_reg == 4'd15) begin
              shift_reg      <= {sample, shift_reg[7:1]};
              parity_acc_reg <= parity_acc_reg ^ sample;
              bit_idx_reg    <= bit_idx_reg + 3'd1;
              if (bit_idx_reg == 3'd7) state_reg <= parity_on ? RX_PARITY : RX_STOP;
            end
          end
        end
        RX_PARITY: begin
          if (os_tick) begin
            os_cnt_reg <= os_cnt_reg + 4'd1;
            if (os_cnt_reg == 4'd15) begin
              parity_bad_reg <= (parity_type == PARITY_ODD) ? ~(parity_acc_reg ^ sample)
                                                            :  (parity_acc_reg ^ sample);
              state_reg <= RX_STOP;
            end
          end
        end
        RX_STOP: begin
          if (os_tick) begin
            os_cnt_reg <= os_cnt_reg + 4'd1;
            if (os_cnt_reg == 4'd15) begin
              rx_data_reg   <= shift_reg;
              byte_done_reg <= 1'b1;
              byte_err_reg  <= parity_bad_reg | ~sample;
              rx_active_reg <= 1'b0;
              state_reg     <= RX_IDLE;
            end
          end
        end
        default: state_reg <= RX_IDLE;
      endcase
    end
  end

  assign rx_data   = rx_data_reg;
  assign byte_done = byte_done_reg;
  assign byte_err  = byte_err_reg;
  assign rx_active = rx_active_reg;

endmodule

// File: rtl/uart_vitals_receive.sv
// Vitals frame receiver: reassembles HR_LO, HR_HI, SpO2, 0x0A frames from
// the byte receiver and publishes them only when the whole frame is good.
// Optional inter-byte timeout is compiled in with VITALS_RX_TIMEOUT_EN.
module uart_vitals_receive
  import vitals_uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 50_000_000,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        data_rx,
  input  logic [1:0]  parity_type,
  input  logic [1:0]  baud_rate,
  output logic [15:0] heart_rate,
  output logic [7:0]  spo2,
  output logic        frame_valid,
  output logic        frame_error,
  output logic        rx_active
);

  asm_state_t  state_reg;
  logic [7:0]  rx_byte;
  logic        byte_done, byte_err, byte_good, timeout_hit;
  logic [7:0]  hr_lo_reg, hr_hi_reg, spo2_sh_reg;
  logic [15:0] heart_rate_reg;
  logic [7:0]  spo2_reg;
  logic        frame_valid_reg, frame_error_reg;

  uart_rx_byte #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_rx_byte (
    .clock       (clock),
    .rst_n       (rst_n),
    .data_rx     (data_rx),
    .parity_type (parity_type),
    .baud_rate   (baud_rate),
    .rx_data     (rx_byte),
    .byte_done   (byte_done),
    .byte_err    (byte_err),
    .rx_active   (rx_active)
  );

  assign byte_good = byte_done & ~byte_err;

`ifdef VITALS_RX_TIMEOUT_EN
  logic [19:0] bit_div_table [4];
  logic [19:0] bit_div, bit_cnt_reg;
  logic [15:0] to_cnt_reg;
  logic        to_armed, bit_wrap;

  for (genvar gi = 0; gi < 4; gi++) begin : g_bit_div
    assign bit_div_table[gi] = 20'(tick_div_for(CLK_FREQ_HZ, 2'(gi)) * OVERSAMPLE);
  end

  assign bit_div     = bit_div_table[baud_rate];
  assign to_armed    = (state_reg == ASM_WAIT_HI) || (state_reg == ASM_WAIT_SPO2) ||
                       (state_reg == ASM_WAIT_NL);
  assign bit_wrap    = (bit_cnt_reg == bit_div - 20'd1);
  assign timeout_hit = to_armed && bit_wrap && (to_cnt_reg == 16'(TIMEOUT_BITS - 1));

  // Count bit periods since the last good byte while a frame is in progress
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_reg <= 20'd0;
      to_cnt_reg  <= 16'd0;
    end else if (byte_good) begin
      bit_cnt_reg <= 20'd0;
      to_cnt_reg  <= 16'd0;
    end else if (to_armed) begin
      if (bit_wrap) begin
        bit_cnt_reg <= 20'd0;
        to_cnt_reg  <= to_cnt_reg + 16'd1;
      end else begin
        bit_cnt_reg <= bit_cnt_reg + 20'd1;
      end
    end
  end
`else
  // No timeout in this build; TIMEOUT_BITS has no effect.
  assign timeout_hit = 1'b0 & (TIMEOUT_BITS != 0);
`endif

  // Frame assembler: shadow bytes until the terminator confirms the frame
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ASM_HUNT;
      hr_lo_reg       <= 8'd0;
      hr_hi_reg       <= 8'd0;
      spo2_sh_reg     <= 8'd0;
      heart_rate_reg  <= 16'd0;
      spo2_reg        <= 8'd0;
      frame_valid_reg <= 1'b0;
      frame_error_reg <= 1'b0;
    end else begin
      frame_valid_reg <= 1'b0;
      frame_error_reg <= 1'b0;
      if (byte_done) begin
        if (state_reg == ASM_HUNT) begin
          if (byte_good && rx_byte == NEWLINE_BYTE) state_reg <= ASM_WAIT_LO;
        end else if (byte_err) begin
          frame_error_reg <= 1'b1;
          hr_lo_reg       <= 8'd0;
          hr_hi_reg       <= 8'd0;
          spo2_sh_reg     <= 8'd0;
          state_reg       <= ASM_HUNT;
        end else begin
          case (state_reg)
            ASM_WAIT_LO: begin
              hr_lo_reg <= rx_byte;
              state_reg <= ASM_WAIT_HI;
            end
            ASM_WAIT_HI: begin
              hr_hi_reg <= rx_byte;
              state_reg <= ASM_WAIT_SPO2;
            end
            ASM_WAIT_SPO2: begin
              spo2_sh_reg <= rx_byte;
              state_reg   <= ASM_WAIT_NL;
            end
            ASM_WAIT_NL: begin
              if (rx_byte == NEWLINE_BYTE) begin
                heart_rate_reg  <= {hr_hi_reg, hr_lo_reg};
                spo2_reg        <= spo2_sh_reg;
                frame_valid_reg <= 1'b1;
                state_reg       <= ASM_WAIT_LO;
              end else begin
                frame_error_reg <= 1'b1;
                state_reg       <= ASM_HUNT;
              end
            end
            default: state_reg <= ASM_HUNT;
          endcase
        end
      end else if (timeout_hit) begin
        frame_error_reg <= 1'b1;
        hr_lo_reg       <= 8'd0;
        hr_hi_reg       <= 8'd0;
        spo2_sh_reg     <= 8'd0;
        state_reg       <= ASM_HUNT;
      end
    end
  end

  assign heart_rate  = heart_rate_reg;
  assign spo2        = spo2_reg;
  assign frame_valid = frame_valid_reg;
  assign frame_error = frame_error_reg;

endmodule

// File: tb/tb_uart_vitals_receive.sv
// Directed bench for uart_vitals_receive. Clock is 614.4 kHz so the bit
// periods are short: 256/128/64/32 clocks for 2400/4800/9600/19200 baud.
module tb_uart_vitals_receive;
  import vitals_uart_pkg::*;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        data_rx;
  logic [1:0]  parity_type;
  logic [1:0]  baud_rate;
  logic [15:0] heart_rate;
  logic [7:0]  spo2;
  logic        frame_valid, frame_error, rx_active;

  int tests = 0;
  int fails = 0;
  int nv_cnt = 0;
  int ne_cnt = 0;

  uart_vitals_receive #(.CLK_FREQ_HZ(614_400), .TIMEOUT_BITS(40)) dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .data_rx     (data_rx),
    .parity_type (parity_type),
    .baud_rate   (baud_rate),
    .heart_rate  (heart_rate),
    .spo2        (spo2),
    .frame_valid (frame_valid),
    .frame_error (frame_error),
    .rx_active   (rx_active)
  );

  always #5 clock = ~clock;

  // Pulse counters: one count per high cycle, so a stretched pulse shows up
  always @(negedge clock) begin
    if (frame_valid) nv_cnt++;
    if (frame_error) ne_cnt++;
  end

  function automatic int bit_cycles(input logic [1:0] code);
    case (code)
      2'b00:   return 256;
      2'b01:   return 128;
      2'b10:   return 64;
      default: return 32;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
    $display("[TB] %s observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit flip_par);
    int bc;
    logic p;
    bc = bit_cycles(baud_rate);
    data_rx = 1'b0;
    idle(bc);
    for (int i = 0; i < 8; i++) begin
      data_rx = b[i];
      idle(bc);
    end
    if (parity_type == 2'b01 || parity_type == 2'b10) begin
      p = (parity_type == 2'b01) ? ~(^b) : (^b);
      data_rx = p ^ flip_par;
      idle(bc);
    end
    data_rx = 1'b1;
    idle(bc);
  endtask

  task automatic send_frame(input logic [15:0] hr, input logic [7:0] sp);
    send_byte(hr[7:0], 1'b0);
    send_byte(hr[15:8], 1'b0);
    send_byte(sp, 1'b0);
    send_byte(8'h0A, 1'b0);
    idle(8);
  endtask

  initial begin
    rst_n       = 1'b0;
    data_rx     = 1'b1;
    parity_type = 2'b10;
    baud_rate   = 2'b10;
    idle(5);
    check("reset_hr", 32'(heart_rate), 32'h0);
    check("reset_spo2", 32'(spo2), 32'h0);
    check("reset_valid", 32'(frame_valid), 32'h0);
    check("reset_error", 32'(frame_error), 32'h0);
    check("reset_active", 32'(rx_active), 32'h0);
    rst_n = 1'b1;
    idle(20);

    // Short 4-clock glitch: start phase entered then rejected at mid start bit
    data_rx = 1'b0;
    idle(4);
    data_rx = 1'b1;
    idle(10);
    check("glitch4_active_start", 32'(rx_active), 32'h1);
    idle(40);
    check("glitch4_rejected", 32'(rx_active), 32'h0);
    idle(64);
    // 1.5-bit low pulse: a real start bit, reception continues into data
    data_rx = 1'b0;
    idle(96);
    data_rx = 1'b1;
    idle(100);
    check("glitch96_active_data", 32'(rx_active), 32'h1);
    idle(768);
    check("glitch96_done", 32'(rx_active), 32'h0);
    check("glitch_no_valid", 32'(nv_cnt), 32'd0);
    check("glitch_no_error", 32'(ne_cnt), 32'd0);

    // Lock on a terminator, then one good frame at 9600 even parity
    send_byte(8'h0A, 1'b0);
    idle(8);
    check("lock_no_valid", 32'(nv_cnt), 32'd0);
    check("lock_no_error", 32'(ne_cnt), 32'd0);
    send_frame(16'h0048, 8'h62);
    check("f1_hr", 32'(heart_rate), 32'h0048);
    check("f1_spo2", 32'(spo2), 32'h62);
    check("f1_valid_once", 32'(nv_cnt), 32'd1);
    check("f1_no_error", 32'(ne_cnt), 32'd0);

    // Bad terminator 0x55
    send_byte(8'h48, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h62, 1'b0);
    send_byte(8'h55, 1'b0);
    idle(8);
    check("badnl_error", 32'(ne_cnt), 32'd1);
    check("badnl_no_valid", 32'(nv_cnt), 32'd1);
    check("badnl_hr_hold", 32'(heart_rate), 32'h0048);
    // In HUNT a complete-looking frame only relocks on its terminator
    send_frame(16'h0010, 8'h50);
    check("hunt_no_valid", 32'(nv_cnt), 32'd1);
    check("hunt_hr_hold", 32'(heart_rate), 32'h0048);
    send_frame(16'h0150, 8'h5F);
    check("f2_hr", 32'(heart_rate), 32'h0150);
    check("f2_spo2", 32'(spo2), 32'h5F);
    check("f2_valid", 32'(nv_cnt), 32'd2);

    // Odd parity, HR_HI parity bit flipped
    parity_type = 2'b01;
    idle(8);
    send_byte(8'h3C, 1'b0);
    send_byte(8'h00, 1'b1);
    send_byte(8'h60, 1'b0);
    send_byte(8'h0A, 1'b0);
    idle(8);
    check("par_error", 32'(ne_cnt), 32'd2);
    check("par_no_valid", 32'(nv_cnt), 32'd2);
    check("par_hr_hold", 32'(heart_rate), 32'h0150);
    send_frame(16'h003C, 8'h60);
    check("par_resync_hr", 32'(heart_rate), 32'h003C);
    check("par_resync_valid", 32'(nv_cnt), 32'd3);

    // All four baud codes with 0x00 / 0xFF payloads, parity off
    for (int k = 0; k < 4; k++) begin
      baud_rate   = 2'(k);
      parity_type = (k % 2 == 1) ? 2'b11 : 2'b00;
      idle(8);
      if (k % 2 == 0) begin
        send_frame(16'hFF00, 8'h00);
        check($sformatf("baud%0d_hr", k), 32'(heart_rate), 32'hFF00);
        check($sformatf("baud%0d_spo2", k), 32'(spo2), 32'h00);
      end else begin
        send_frame(16'h00FF, 8'hFF);
        check($sformatf("baud%0d_hr", k), 32'(heart_rate), 32'h00FF);
        check($sformatf("baud%0d_spo2", k), 32'(spo2), 32'hFF);
      end
      check($sformatf("baud%0d_valid", k), 32'(nv_cnt), 32'(4 + k));
    end

    // Reset for 3 cycles in the middle of the SpO2 byte
    baud_rate   = 2'b10;
    parity_type = 2'b10;
    idle(8);
    send_byte(8'h50, 1'b0);
    send_byte(8'h00, 1'b0);
    fork
      send_byte(8'h62, 1'b0);
      begin
        idle(224);
        rst_n = 1'b0;
        idle(2);
        check("rst_mid_hr", 32'(heart_rate), 32'h0);
        check("rst_mid_spo2", 32'(spo2), 32'h0);
        idle(1);
        rst_n = 1'b1;
      end
    join
    idle(200);
    check("rst_after_no_valid", 32'(nv_cnt), 32'd7);
    check("rst_after_no_error", 32'(ne_cnt), 32'd2);
    send_frame(16'h0055, 8'h61);
    check("rst_hunt_no_valid", 32'(nv_cnt), 32'd7);
    check("rst_hunt_hr", 32'(heart_rate), 32'h0);
    send_frame(16'h0048, 8'h62);
    check("rst_recover_hr", 32'(heart_rate), 32'h0048);
    check("rst_recover_spo2", 32'(spo2), 32'h62);
    check("rst_recover_valid", 32'(nv_cnt), 32'd8);

    // Stall 41 bit times after HR_LO, then finish the frame
    send_byte(8'h4B, 1'b0);
    idle(41 * 64);
`ifdef VITALS_RX_TIMEOUT_EN
    check("stall_error", 32'(ne_cnt), 32'd3);
`else
    check("stall_no_error", 32'(ne_cnt), 32'd2);
`endif
    send_byte(8'h00, 1'b0);
    send_byte(8'h62, 1'b0);
    send_byte(8'h0A, 1'b0);
    idle(8);
`ifdef VITALS_RX_TIMEOUT_EN
    check("stall_resume_no_valid", 32'(nv_cnt), 32'd8);
    check("stall_resume_hr", 32'(heart_rate), 32'h0048);
    check("stall_error_once", 32'(ne_cnt), 32'd3);
`else
    check("stall_resume_valid", 32'(nv_cnt), 32'd9);
    check("stall_resume_hr", 32'(heart_rate), 32'h004B);
    check("stall_resume_no_error", 32'(ne_cnt), 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_vitals_receive.md
# uart_vitals_receive

Receive-side counterpart of the vitals UART link: deserialises the serial line and reassembles 4-byte vitals frames (heart-rate low byte, heart-rate high byte, SpO2, 0x0A terminator) into parallel heart_rate/spo2 registers. It sits on the monitoring/host side of the cold-storage board and uses the same parity_type/baud_rate agreement as the transmitting end. Corrupt bytes or frames are discarded, and the block resynchronises on the next terminator.

## Interface
- CLK_FREQ_HZ, 50_000_000, system clock frequency used to derive bit timing
- TIMEOUT_BITS, 40, inter-byte timeout in bit periods (only with the timeout macro)
- clock  in  1  system clock; all logic on its rising edge
- rst_n  in  1  asynchronous active-low reset
- data_rx  in  1  UART RX line; idle high
- parity_type  in  2  00 none, 01 odd, 10 even, 11 none
- baud_rate  in  2  00 2400, 01 4800, 10 9600, 11 19200
- heart_rate  out  16  last valid heart rate, little-endian reassembled
- spo2  out  8  last valid SpO2
- frame_valid  out  1  one-cycle pulse when heart_rate/spo2 update
- frame_error  out  1  one-cycle pulse on byte error, bad terminator or timeout
- rx_active  out  1  high while a byte is being received (start bit through stop bit)

## Operation
- data_rx passes through a 2-flop synchroniser. Reset value of both stages is 1.
- Bit timing: 16x oversampling. tick_div = CLK_FREQ_HZ / (baud × 16), truncated.
- Serial format: start bit, 8 data bits LSB first, parity bit only when parity_type is 01/10, then 1 stop bit.
- Byte receiver states: IDLE → START → DATA → PARITY (skipped when parity is off) → STOP → IDLE.
  - IDLE → START on a synchronised falling edge.
  - At tick 8 of the start bit the line is sampled again; if it is high, the edge is a glitch and the receiver returns to IDLE with no error.
  - All other bits are sampled at tick 8 of their bit period.
- Byte error: parity mismatch, or stop bit sampled low.
  - Odd parity: the XOR of the data bits and the parity bit must be 1.
  - Even parity: the same XOR must be 0.
- Frame assembler states: HUNT, WAIT_LO, WAIT_HI, WAIT_SPO2, WAIT_NL. Reset state is HUNT.
  - HUNT: a good byte equal to 0x0A → WAIT_LO. Any other byte, or any byte error, stays in HUNT with no error pulse.
  - WAIT_LO / WAIT_HI / WAIT_SPO2: store the byte into a shadow register and advance to the next state.
  - WAIT_NL with 0x0A: copy the shadow registers to heart_rate/spo2, pulse frame_valid, → WAIT_LO.
  - WAIT_NL with any other byte: pulse frame_error, → HUNT.
  - A byte error in any WAIT_* state: pulse frame_error, discard the shadow registers, → HUNT.
- heart_rate/spo2 change only on a frame_valid cycle and hold otherwise. Partial frames never leak to the outputs.
- A change of parity_type or baud_rate mid-byte is unsupported; the byte may be corrupted and the error path handles it.

## Timing
- Reset values: heart_rate=0, spo2=0, frame_valid=0, frame_error=0, rx_active=0. The assembler starts in HUNT.
- Reset asserted mid-byte or mid-frame: everything clears immediately. After release the receiver waits for line idle, then a falling edge.
- Byte completion is the stop-bit sample (tick 8 of the stop bit).
- frame_valid/frame_error assert on the clock edge after the completing byte's stop-bit sample and last exactly 1 cycle.
- rx_active rises 1 cycle after the falling edge is detected, and falls on the cycle of the stop-bit sample or the glitch reject.
- Input-to-detection latency is 2 cycles (synchroniser).
- The receiver re-arms for a new start bit immediately after the stop-bit sample, so back-to-back bytes with zero idle time are supported.

## Configuration
- VITALS_RX_TIMEOUT_EN defined: a counter runs in WAIT_HI, WAIT_SPO2 and WAIT_NL.
  - It counts bit periods and is cleared by each good byte.
  - Reaching TIMEOUT_BITS pulses frame_error and moves to HUNT.
  - The counter is frozen in HUNT and WAIT_LO.
- VITALS_RX_TIMEOUT_EN undefined: no timeout; a stalled partial frame waits indefinitely. TIMEOUT_BITS is ignored.

## Structure
- Package vitals_uart_pkg contains:
  - parity encodings (PARITY_NONE, PARITY_ODD, PARITY_EVEN)
  - baud encodings and their rate constants
  - OVERSAMPLE=16 and NEWLINE_BYTE=8'h0A
  - the assembler state enum
- Sub-module uart_rx_byte contains the synchroniser, divider and bit state machine. It outputs a byte, a byte_done pulse, byte_err and rx_active.
- The top level holds the frame assembler, shadow registers and the optional timeout.

## Test plan
- Reset, then send 0x0A followed by a frame of HR=0x0048 and SpO2=0x62 at 9600 baud with even parity → first terminator only locks (no pulse); the frame gives heart_rate=0x0048, spo2=0x62 and a single frame_valid pulse.
- Locked receiver, frame 48 00 62 55 (bad terminator) → frame_error pulse, outputs unchanged, state HUNT. Then 0A and a good frame → frame_valid.
- Odd parity selected, flip the parity bit of the HR_HI byte → frame_error, no output update. Resynchronisation on the next 0x0A.
- 1.5-bit-time low glitch vs. 4-clock low glitch on an idle line → the 4-clock glitch is rejected (no rx_active beyond the start phase, no byte). Test all four baud_rate codes with 0x00/0xFF payloads.
- Assert rst_n for 3 cycles in the middle of the SpO2 byte → all outputs 0 and no pulses until a full new terminator plus frame arrives.
- With VITALS_RX_TIMEOUT_EN, stop after HR_LO for 41 bit times → exactly one frame_error. Without the macro, the same stimulus gives no pulse and the frame completes when resumed.
